// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit for the EX stage: multi-cycle multiplier plus 1-bit/cycle restoring divider.
// Optional `MULDIV_EARLY_OUT_EN: trivial divides (by zero, overflow, |a|<|b|) finish straight from idle.
module ex_muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic            FLUSH,
  input  logic [2:0]      OP,
  input  logic [XLEN-1:0] OPERAND1,
  input  logic [XLEN-1:0] OPERAND2,
  output logic [XLEN-1:0] RESULT,
  output logic            DONE,
  output logic            BUSY
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int CW = $clog2((XLEN > MUL_CYCLES) ? XLEN : MUL_CYCLES);
  localparam logic [XLEN-1:0] ONE  = XLEN'(1);
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] opa_q, opa_d;   // multiplicand, or dividend magnitude shifting into the quotient
  logic [XLEN-1:0] opb_q, opb_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  logic            sign_a, sign_b;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            mul_sa, mul_sb;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN:0]   shifted, trial;

  // Signed divide ops (DIV/REM) have funct3[0] clear
  assign sign_a = OPERAND1[XLEN-1] & ~OP[0];
  assign sign_b = OPERAND2[XLEN-1] & ~OP[0];
  assign abs_a  = sign_a ? (~OPERAND1 + ONE) : OPERAND1;
  assign abs_b  = sign_b ? (~OPERAND2 + ONE) : OPERAND2;

  // Sign-extend to 2*XLEN; the low 2*XLEN bits of the wrapped product are exact
  assign mul_sa = (op_q == 3'd1 || op_q == 3'd2) & opa_q[XLEN-1];
  assign mul_sb = (op_q == 3'd1) & opb_q[XLEN-1];
  assign mul_a  = {{XLEN{mul_sa}}, opa_q};
  assign mul_b  = {{XLEN{mul_sb}}, opb_q};
  assign prod   = mul_a * mul_b;

  assign shifted = {rem_q, opa_q[XLEN-1]};
  assign trial   = shifted - {1'b0, opb_q};

  assign BUSY   = ((state_q == S_IDLE) & START & ~FLUSH) | (state_q == S_MUL) |
                  (state_q == S_DIV) | (state_q == S_FIX);
  assign RESULT = result_q;
  assign DONE   = done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    rem_d    = rem_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START && !FLUSH) begin
          op_d = OP;
          if (!OP[2]) begin
            opa_d   = OPERAND1;
            opb_d   = OPERAND2;
            cnt_d   = CW'(MUL_CYCLES - 1);
            state_d = S_MUL;
          end else begin
            opa_d   = abs_a;
            opb_d   = abs_b;
            rem_d   = '0;
            negq_d  = (sign_a ^ sign_b) & (OPERAND2 != '0);
            negr_d  = sign_a;
            cnt_d   = CW'(XLEN - 1);
            state_d = S_DIV;
`ifdef MULDIV_EARLY_OUT_EN
            if (OPERAND2 == '0) begin
              result_d = OP[1] ? OPERAND1 : '1;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end else if (!OP[0] && OPERAND1 == XMIN && OPERAND2 == '1) begin
              result_d = OP[1] ? '0 : XMIN;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end else if (abs_a < abs_b) begin
              result_d = OP[1] ? OPERAND1 : '0;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end
`else
            if (OPERAND1 == XMIN && OPERAND2 == '1) negq_d = 1'b0;
`endif
          end
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          result_d = (op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
          done_d   = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        opa_d = {opa_q[XLEN-2:0], ~trial[XLEN]};
        rem_d = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (op_q[1]) result_d = negr_q ? (~rem_q + ONE) : rem_q;
        else         result_d = negq_q ? (~opa_q + ONE) : opa_q;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A kill from EX drops the op silently; the last result stays visible
    if (FLUSH && state_q != S_DONE) begin
      state_d  = S_IDLE;
      result_d = result_q;
      done_d   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      rem_q    <= rem_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: expected results queued at issue, popped on the DONE pulse.
module tb_ex_muldiv_unit;
  logic        CLK = 1'b0;
  logic        RESET, START, FLUSH;
  logic [2:0]  OP;
  logic [31:0] OPERAND1, OPERAND2, RESULT;
  logic        DONE, BUSY;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 CLK = ~CLK;

  ex_muldiv_unit dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FLUSH(FLUSH), .OP(OP),
    .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .RESULT(RESULT), .DONE(DONE), .BUSY(BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'd0, a} * 0 + {32'd0, b})); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    if (!op[2]) return 3;
    ma = (!op[0] && a[31]) ? -a : a;
    mb = (!op[0] && b[31]) ? -b : b;
    if (EARLY && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb)) return 1;
    return 34;
  endfunction

  // Issue in cycle 0, scramble operands afterwards, expect exactly one DONE at the modelled cycle
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          cyc;
    int          lat;
    logic [31:0] exp;
    sb.push_back(model(op, a, b));
    lat = exp_lat(op, a, b);
    OP = op; OPERAND1 = a; OPERAND2 = b; START = 1'b1;
    #1;
    chk({tag, " busy_c0"}, 32'(BUSY), 32'd1);
    cyc = 0;
    forever begin
      tick;
      cyc++;
      OPERAND1 = ~a;
      OPERAND2 = a ^ b;
      if (DONE) break;
      if (cyc > 60) begin
        chk({tag, " timeout"}, 32'(cyc), 32'(lat));
        break;
      end
    end
    exp = sb.pop_front();
    if (DONE) begin
      chk({tag, " latency"}, 32'(cyc), 32'(lat));
      chk({tag, " result"}, RESULT, exp);
      chk({tag, " busy_done"}, 32'(BUSY), 32'd0);
      last_res = exp;
    end
    tick;
    chk({tag, " single_pulse"}, 32'(DONE), 32'd0);
    START = 1'b0;
    #1;
  endtask

  initial begin
    int pulses;
    RESET = 1'b1; START = 1'b0; FLUSH = 1'b0; OP = 3'd0; OPERAND1 = '0; OPERAND2 = '0;
    last_res = '0;
    tick; tick;
    chk("reset result", RESULT, 32'd0);
    chk("reset done", 32'(DONE), 32'd0);
    chk("reset busy", 32'(BUSY), 32'd0);
    RESET = 1'b0;
    tick;

    do_op("mul 7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    do_op("mulh min*min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    do_op("mulhu max*max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhsu -1*max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
    do_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
    do_op("divu 100/7", 3'd5, 32'd100, 32'd7);
    do_op("remu 100/7", 3'd7, 32'd100, 32'd7);
    do_op("div 5/0", 3'd4, 32'd5, 32'd0);
    do_op("rem 5/0", 3'd6, 32'd5, 32'd0);
    do_op("div -5/0", 3'd4, 32'hFFFF_FFFB, 32'd0);
    do_op("divu 5/0", 3'd5, 32'd5, 32'd0);
    do_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("div 3/-10", 3'd4, 32'd3, 32'hFFFF_FFF6);
    do_op("rem 3/-10", 3'd6, 32'd3, 32'hFFFF_FFF6);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      do_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), ra, rb);
    end

    // Flush mid-divide: no DONE, old result kept, then a fresh MUL in cycle 12
    OP = 3'd5; OPERAND1 = 32'd100; OPERAND2 = 32'd7; START = 1'b1;
    for (int c = 0; c < 10; c++) tick;
    FLUSH = 1'b1;
    tick;
    START = 1'b0; FLUSH = 1'b0;
    #1;
    chk("flush busy", 32'(BUSY), 32'd0);
    chk("flush done", 32'(DONE), 32'd0);
    chk("flush result", RESULT, last_res);
    tick;
    do_op("mul after flush", 3'd0, 32'h0001_2345, 32'h0000_0100);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (DONE) pulses++;
    end
    chk("flush stray done", 32'(pulses), 32'd0);

    // FLUSH beats START in idle
    OP = 3'd4; OPERAND1 = 32'd9; OPERAND2 = 32'd2; START = 1'b1; FLUSH = 1'b1;
    #1;
    chk("flush+start busy", 32'(BUSY), 32'd0);
    tick;
    START = 1'b0; FLUSH = 1'b0;
    #1;
    chk("flush+start idle", 32'(BUSY), 32'd0);

    // Reset mid-divide
    OP = 3'd5; OPERAND1 = 32'hDEAD_BEEF; OPERAND2 = 32'd3; START = 1'b1;
    for (int c = 0; c < 5; c++) tick;
    RESET = 1'b1; START = 1'b0;
    tick;
    chk("rst mid result", RESULT, 32'd0);
    chk("rst mid done", 32'(DONE), 32'd0);
    chk("rst mid busy", 32'(BUSY), 32'd0);
    RESET = 1'b0;
    tick;
    do_op("remu after rst", 3'd7, 32'hDEAD_BEEF, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
